// File: rtl/vend_ctrl_gen2.sv
// vend_ctrl_gen2: vending transaction controller.
// Accumulates coin credit, arbitrates buy requests against a price table and
// holds the vend/error indication for HOLD_CYC cycles.
// Optional feature macro: VEND_CHANGE_EN adds a coin-by-coin refund state
// driven over the change_valid/change_ready handshake.
module vend_ctrl_gen2 #(
    parameter int unsigned NUM_PROD = 4,
    parameter int unsigned CREDIT_W = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd75},
    parameter int unsigned HOLD_CYC = 6,
    localparam int unsigned PSEL_W = $clog2(NUM_PROD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                buy,
    input  logic [PSEL_W-1:0]   product,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [PSEL_W-1:0]   vend_id,
    output logic                err,
    output logic                busy,
    output logic [1:0]          disp_mode,
    output logic                change_valid,
    output logic [1:0]          change_coin
);

    localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD
`ifdef VEND_CHANGE_EN
        , S_REFUND
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                vend_valid_q, vend_valid_d;
    logic [PSEL_W-1:0]   vend_id_q, vend_id_d;
    logic                err_q, err_d;
    logic [1:0]          disp_q, disp_d;

    logic [CREDIT_W-1:0] coin_add;
    logic [CREDIT_W:0]   sum_w;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] price;
    logic                prod_ok;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    return CREDIT_W'(1);
            2'd1:    return CREDIT_W'(5);
            2'd2:    return CREDIT_W'(10);
            default: return CREDIT_W'(25);
        endcase
    endfunction

    // Saturating credit after this cycle's coin (if any)
    always_comb begin
        coin_add   = coin_valid ? coin_value(coin_code) : '0;
        sum_w      = {1'b0, credit_q} + {1'b0, coin_add};
        credit_add = sum_w[CREDIT_W] ? '1 : sum_w[CREDIT_W-1:0];
    end

    // Price table lookup; out-of-range indices leave prod_ok low
    always_comb begin
        price   = '0;
        prod_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (product == PSEL_W'(i)) begin
                price   = PRICES[i*CREDIT_W +: CREDIT_W];
                prod_ok = 1'b1;
            end
        end
    end

`ifdef VEND_CHANGE_EN
    logic       chg_valid_q, chg_valid_d;
    logic [1:0] chg_coin_q, chg_coin_d;
    logic [CREDIT_W-1:0] refund_rem;

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(25))      return 2'd3;
        else if (amt >= CREDIT_W'(10)) return 2'd2;
        else if (amt >= CREDIT_W'(5))  return 2'd1;
        else                           return 2'd0;
    endfunction

    // Offered coin is registered so it only changes after an accepted handshake;
    // coins added meanwhile only raise credit, so the offer stays refundable.
    assign refund_rem   = credit_add - coin_value(chg_coin_q);
    assign change_valid = chg_valid_q;
    assign change_coin  = chg_coin_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{cancel, change_ready};
    assign change_valid  = 1'b0;
    assign change_coin   = 2'd0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_add;
        cnt_d        = cnt_q;
        vend_valid_d = 1'b0;
        vend_id_d    = vend_id_q;
        err_d        = 1'b0;
        disp_d       = disp_q;
`ifdef VEND_CHANGE_EN
        chg_valid_d  = chg_valid_q;
        chg_coin_d   = chg_coin_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (buy) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    if (prod_ok && (credit_q >= price)) begin
                        vend_valid_d = 1'b1;
                        vend_id_d    = product;
                        credit_d     = credit_add - price;
                        disp_d       = 2'd1;
                    end else begin
                        err_d  = 1'b1;
                        disp_d = 2'd2;
                    end
                end
`ifdef VEND_CHANGE_EN
                else if (cancel && (credit_q != '0)) begin
                    state_d     = S_REFUND;
                    disp_d      = 2'd0;
                    chg_valid_d = 1'b1;
                    chg_coin_d  = greedy_coin(credit_add);
                end
`endif
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    disp_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef VEND_CHANGE_EN
            S_REFUND: begin
                if (chg_valid_q && change_ready) begin
                    credit_d = refund_rem;
                    if (refund_rem == '0) begin
                        state_d     = S_IDLE;
                        chg_valid_d = 1'b0;
                        chg_coin_d  = 2'd0;
                    end else begin
                        chg_coin_d  = greedy_coin(refund_rem);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            cnt_q        <= '0;
            vend_valid_q <= 1'b0;
            vend_id_q    <= '0;
            err_q        <= 1'b0;
            disp_q       <= 2'd0;
`ifdef VEND_CHANGE_EN
            chg_valid_q  <= 1'b0;
            chg_coin_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            cnt_q        <= cnt_d;
            vend_valid_q <= vend_valid_d;
            vend_id_q    <= vend_id_d;
            err_q        <= err_d;
            disp_q       <= disp_d;
`ifdef VEND_CHANGE_EN
            chg_valid_q  <= chg_valid_d;
            chg_coin_q   <= chg_coin_d;
`endif
        end
    end

    assign credit     = credit_q;
    assign vend_valid = vend_valid_q;
    assign vend_id    = vend_id_q;
    assign err        = err_q;
    assign disp_mode  = disp_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl_gen2.sv
// Directed bench for vend_ctrl_gen2 (NUM_PROD=4, CREDIT_W=8, prices 75/20/30/40, HOLD_CYC=6).
// Covers the default build and, when VEND_CHANGE_EN is defined, the refund path.
module tb_vend_ctrl_gen2;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       buy;
    logic [1:0] product;
    logic       cancel;
    logic       change_ready;
    logic [7:0] credit;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       err;
    logic       busy;
    logic [1:0] disp_mode;
    logic       change_valid;
    logic [1:0] change_coin;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    vend_ctrl_gen2 #(
        .NUM_PROD (4),
        .CREDIT_W (8),
        .PRICES   ({8'd40, 8'd30, 8'd20, 8'd75}),
        .HOLD_CYC (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .buy          (buy),
        .product      (product),
        .cancel       (cancel),
        .change_ready (change_ready),
        .credit       (credit),
        .vend_valid   (vend_valid),
        .vend_id      (vend_id),
        .err          (err),
        .busy         (busy),
        .disp_mode    (disp_mode),
        .change_valid (change_valid),
        .change_coin  (change_coin)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            tick();
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Observe a whole HOLD window, starting in the cycle after the buy edge
    task automatic run_hold(input string tag, input logic [1:0] mode);
        int nb  = 0;
        int nv  = 0;
        int ne  = 0;
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nb++;
            nv += int'(vend_valid);
            ne += int'(err);
            if (disp_mode !== mode) bad++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(nb), 6);
        chk({tag, "_vend_pulses"}, 32'(nv), (mode == 2'd1) ? 1 : 0);
        chk({tag, "_err_pulses"},  32'(ne), (mode == 2'd2) ? 1 : 0);
        chk({tag, "_hold_mode"},   32'(bad), 0);
        chk({tag, "_mode_after"},  32'(disp_mode), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_cr [3];
        reset        = 1'b0;
        coin_valid   = 1'b0;
        coin_code    = 2'd0;
        buy          = 1'b0;
        product      = 2'd0;
        cancel       = 1'b0;
        change_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vend", 32'(vend_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_disp", 32'(disp_mode), 0);
        chk("rst_chg", 32'(change_valid), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // T2: three quarters then buy product 0 (75)
        put_coin(2'd3);
        chk("t2_credit25", 32'(credit), 25);
        put_coin(2'd3);
        put_coin(2'd3);
        chk("t2_credit75", 32'(credit), 75);
        buy = 1'b1; product = 2'd0;
        tick();
        buy = 1'b0;
        chk("t2_vend", 32'(vend_valid), 1);
        chk("t2_vend_id", 32'(vend_id), 0);
        chk("t2_credit0", 32'(credit), 0);
        chk("t2_disp", 32'(disp_mode), 1);
        run_hold("t2", 2'd1);

        // T3: credit 15, product 1 (20) rejected
        put_coin(2'd2);
        put_coin(2'd1);
        chk("t3_credit15", 32'(credit), 15);
        buy = 1'b1; product = 2'd1;
        tick();
        buy = 1'b0;
        chk("t3_err", 32'(err), 1);
        chk("t3_vend", 32'(vend_valid), 0);
        chk("t3_disp", 32'(disp_mode), 2);
        chk("t3_credit_held", 32'(credit), 15);
        run_hold("t3", 2'd2);
        chk("t3_credit_after", 32'(credit), 15);

        // T4: saturation, then three vends of product 0 down to 30
        for (int i = 0; i < 11; i++) put_coin(2'd3);
        chk("t4_sat", 32'(credit), 255);
        exp_cr = '{180, 105, 30};
        for (int k = 0; k < 3; k++) begin
            buy = 1'b1; product = 2'd0;
            tick();
            buy = 1'b0;
            chk($sformatf("t4_vend_credit%0d", k), 32'(credit), 32'(exp_cr[k]));
            wait_idle("t4_vend");
        end
        // Coin and buy in the same cycle: decision on credit 30 < 40
        coin_valid = 1'b1; coin_code = 2'd3; buy = 1'b1; product = 2'd3;
        tick();
        coin_valid = 1'b0; buy = 1'b0;
        chk("t4_err", 32'(err), 1);
        chk("t4_novend", 32'(vend_valid), 0);
        chk("t4_credit55", 32'(credit), 55);
        wait_idle("t4_err");

        // buy + cancel together: buy wins
        buy = 1'b1; cancel = 1'b1; product = 2'd1;
        tick();
        buy = 1'b0; cancel = 1'b0;
        chk("bc_vend", 32'(vend_valid), 1);
        chk("bc_vend_id", 32'(vend_id), 1);
        chk("bc_credit", 32'(credit), 35);
        chk("bc_disp", 32'(disp_mode), 1);
        chk("bc_nochg", 32'(change_valid), 0);
        wait_idle("bc");

        // Reach credit 41: 35-20=15, +25+1
        buy = 1'b1; product = 2'd1;
        tick();
        buy = 1'b0;
        chk("pre_credit15", 32'(credit), 15);
        wait_idle("pre");
        put_coin(2'd3);
        put_coin(2'd0);
        chk("pre_credit41", 32'(credit), 41);

`ifdef VEND_CHANGE_EN
        begin
            logic [1:0] got [$];
            logic [1:0] exp_coin [4];
            logic [1:0] prev_coin;
            logic       prev_valid;
            int         stable_bad = 0;
            int         mode_bad   = 0;
            exp_coin = '{2'd3, 2'd2, 2'd1, 2'd0};
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            chk("t5_busy", 32'(busy), 1);
            chk("t5_chg_valid", 32'(change_valid), 1);
            chk("t5_first_coin", 32'(change_coin), 3);
            chk("t5_disp", 32'(disp_mode), 0);
            for (int i = 0; i < 40; i++) begin
                if (!busy) break;
                change_ready = (i % 2 == 0);
                if (change_valid && change_ready) got.push_back(change_coin);
                prev_coin  = change_coin;
                prev_valid = change_valid;
                tick();
                if (!change_ready && ((change_valid !== prev_valid) || (change_coin !== prev_coin)))
                    stable_bad++;
                if (busy && (disp_mode !== 2'd0)) mode_bad++;
            end
            change_ready = 1'b0;
            chk("t5_coin_count", 32'(got.size()), 4);
            for (int k = 0; k < 4; k++)
                chk($sformatf("t5_coin%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF,
                    32'(exp_coin[k]));
            chk("t5_stable", 32'(stable_bad), 0);
            chk("t5_mode", 32'(mode_bad), 0);
            chk("t5_credit0", 32'(credit), 0);
            chk("t5_idle", 32'(busy), 0);
            chk("t5_chg_off", 32'(change_valid), 0);
        end
`else
        change_ready = 1'b1;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t6_nochg", 32'(change_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_credit", 32'(credit), 41);
        tick();
        chk("t6_credit_later", 32'(credit), 41);
        chk("t6_coin", 32'(change_coin), 0);
        change_ready = 1'b0;
`endif

        // T1: async reset while vend_valid is high and HOLD is active
        put_coin(2'd3);
        put_coin(2'd3);
`ifdef VEND_CHANGE_EN
        chk("t1_credit", 32'(credit), 50);
`else
        chk("t1_credit", 32'(credit), 91);
`endif
        buy = 1'b1; product = 2'd2;
        tick();
        buy = 1'b0;
        chk("t1_vend", 32'(vend_valid), 1);
        chk("t1_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_credit", 32'(credit), 0);
        chk("t1_async_busy", 32'(busy), 0);
        chk("t1_async_vend", 32'(vend_valid), 0);
        chk("t1_async_err", 32'(err), 0);
        chk("t1_async_chg", 32'(change_valid), 0);
        chk("t1_async_disp", 32'(disp_mode), 0);
        tick();
        tick();
        reset = 1'b1;
        begin
            int pulses = 0;
            int busy_n = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                pulses += int'(vend_valid) + int'(err) + int'(change_valid);
                busy_n += int'(busy);
            end
            chk("t1_no_pulses", 32'(pulses), 0);
            chk("t1_no_busy", 32'(busy_n), 0);
            chk("t1_credit_after", 32'(credit), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
